// File: rtl/addsub_share_ctrl_pkg.sv
// Shared types and constants for the addsub32 sharing controller.
// Holds the controller state encoding, the requester-id width and the
// captured-result record used by the top level.
package addsub_share_ctrl_pkg;

  // Operand and result width of the shared adder.
  localparam int DATA_W = 32;

  // Width of the requester id carried with every response.
  localparam int RSP_ID_W = 1;

  // Number of requesters sharing the datapath.
  localparam int N_REQ = 2;

  // Controller states. The 2'd3 code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Result sampled from the adder at the end of the settle window.
  typedef struct packed {
    logic [DATA_W-1:0] ans;
    logic              cout;
    logic              v;
  } result_t;

  // Round-robin helper: the requester that did not win last time.
  function automatic logic [RSP_ID_W-1:0] rr_other(input logic [RSP_ID_W-1:0] id);
    return ~id;
  endfunction

endpackage

// File: rtl/addsub_share_ctrl_addsub32.sv
// addsub32: 32-bit ripple-carry adder/subtractor, two's complement.
// Subtraction is A + ~B + 1: B is inverted bitwise and the subtract flag
// is injected as the carry into bit 0. V compares the carries into and out
// of the sign bit.
module addsub32
  import addsub_share_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_ans,
  output logic              o_cout,
  output logic              o_v
);

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_c;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      // Conditionally invert B for subtraction.
      assign w_b_eff[gi] = i_b[gi] ^ i_sub;
      // Full-adder sum bit.
      assign o_ans[gi]   = i_a[gi] ^ w_b_eff[gi] ^ w_c[gi];
    end
  endgenerate

  // Carry chain, rippled from bit 0 upward within one process.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_sub;
    for (int i = 0; i < DATA_W; i++) begin
      w_c[i+1] = (i_a[i] & w_b_eff[i]) | (w_c[i] & (i_a[i] ^ w_b_eff[i]));
    end
  end

  assign o_cout = w_c[DATA_W];
  assign o_v    = w_c[DATA_W] ^ w_c[DATA_W-1];

endmodule

// File: rtl/addsub_share_ctrl_arb.sv
// rr_arb2: combinational two-way round-robin arbiter.
// A single valid requester always wins; when both are valid the one that
// did not win the previous grant is chosen, so neither can be starved.
module rr_arb2
  import addsub_share_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0]    i_valid,
  input  logic [RSP_ID_W-1:0] i_last_grant,
  output logic                o_grant_valid,
  output logic [RSP_ID_W-1:0] o_grant_id
);

  // Pick the winner from the request vector and the previous winner.
  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = '0;
    case (i_valid)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = rr_other(i_last_grant);
      default: o_grant_id = '0;
    endcase
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl: shares one addsub32 between two requesters.
// A request is accepted in IDLE, its operands are latched and held on the
// adder for SETTLE_CYCLES clocks, then the result is captured and offered
// on the response port until the consumer takes it. The controller only
// sequences; all arithmetic comes from the addsub32 instance.
module addsub_share_ctrl
  import addsub_share_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [DATA_W-1:0]   r0_a,
  input  logic [DATA_W-1:0]   r0_b,
  input  logic                r0_sub,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [DATA_W-1:0]   r1_a,
  input  logic [DATA_W-1:0]   r1_b,
  input  logic                r1_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RSP_ID_W-1:0] rsp_id,
  output logic [DATA_W-1:0]   rsp_ans,
  output logic                rsp_cout,
  output logic                rsp_v,
  output logic                busy
);

  // Load value for the settle counter: counts SETTLE_CYCLES-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_next;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_sub;
  logic [RSP_ID_W-1:0] r_id;
  logic [RSP_ID_W-1:0] r_last_grant;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_rsp_valid;
  logic [RSP_ID_W-1:0] r_rsp_id;
  result_t             r_rsp;

  logic [N_REQ-1:0]    w_req_valid;
  logic [N_REQ-1:0]    w_ready;
  logic                w_grant_valid;
  logic [RSP_ID_W-1:0] w_grant_id;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_sel_sub;

  logic                w_accept;
  logic                w_settle_done;
  logic                w_rsp_take;
  logic                w_busy;

  logic [DATA_W-1:0]   w_sum;
  logic                w_cout;
  logic                w_v;
  result_t             w_res;

  assign w_req_valid = {r1_valid, r0_valid};

  rr_arb2 u_arb (
    .i_valid       (w_req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Operands of the requester currently being granted.
  assign w_sel_a   = (w_grant_id == 1'b1) ? r1_a   : r0_a;
  assign w_sel_b   = (w_grant_id == 1'b1) ? r1_b   : r0_b;
  assign w_sel_sub = (w_grant_id == 1'b1) ? r1_sub : r0_sub;

  // The adder only ever sees the latched operands, so later changes on the
  // request ports cannot disturb an operation that is settling.
  addsub32 u_addsub (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sub  (r_sub),
    .o_ans  (w_sum),
    .o_cout (w_cout),
    .o_v    (w_v)
  );

  assign w_res.ans  = w_sum;
  assign w_res.cout = w_cout;
  assign w_res.v    = w_v;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> SETTLE -> RESP -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_valid)  w_state_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0)    w_state_next = ST_RESP;
      ST_RESP:   if (rsp_ready)      w_state_next = ST_IDLE;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded strobes; ready is only offered while idle.
  always_comb begin
    w_accept      = 1'b0;
    w_settle_done = 1'b0;
    w_rsp_take    = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_accept = w_grant_valid;
      end
      ST_SETTLE: w_settle_done = (r_cnt == '0);
      ST_RESP:   w_rsp_take    = rsp_ready;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      // Only the granted requester sees ready, and only on an accept cycle.
      assign w_ready[gi] = w_accept && (w_grant_id == RSP_ID_W'(gi));
    end
  endgenerate

  assign r0_ready = w_ready[0];
  assign r1_ready = w_ready[1];
  assign busy     = w_busy;

  // Latch the winning request and remember the winner for the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_id         <= '0;
      r_last_grant <= RSP_ID_W'(1);
    end else if (w_accept) begin
      r_a          <= w_sel_a;
      r_b          <= w_sel_b;
      r_sub        <= w_sel_sub;
      r_id         <= w_grant_id;
      r_last_grant <= w_grant_id;
    end
  end

  // Settle counter: loaded on accept, counts down while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Capture the settled result and run the response handshake; the data
  // registers keep their last value after the response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp       <= '0;
    end else if (w_settle_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp       <= w_res;
    end else if (w_rsp_take) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_ans   = r_rsp.ans;
  assign rsp_cout  = r_rsp.cout;
  assign rsp_v     = r_rsp.v;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl. Two instances (settle 4 and 70) share the
// stimulus; cfg selects which one is observed and checked. A reference
// model tracks the expected FSM phase, grants and results; results are
// queued on accept and compared while the response is offered.
module tb_addsub_share_ctrl;

  typedef struct packed {
    logic        id;
    logic [31:0] ans;
    logic        cout;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0_valid, r1_valid, r0_sub, r1_sub, rsp_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic        d4_r0_ready, d4_r1_ready, d4_rsp_valid, d4_rsp_id, d4_rsp_cout, d4_rsp_v, d4_busy;
  logic [31:0] d4_rsp_ans;
  logic        d70_r0_ready, d70_r1_ready, d70_rsp_valid, d70_rsp_id, d70_rsp_cout, d70_rsp_v, d70_busy;
  logic [31:0] d70_rsp_ans;

  logic        cfg = 1'b0;
  logic        o_r0_ready, o_r1_ready, o_rsp_valid, o_rsp_id, o_rsp_cout, o_rsp_v, o_busy;
  logic [31:0] o_rsp_ans;

  assign o_r0_ready  = cfg ? d70_r0_ready  : d4_r0_ready;
  assign o_r1_ready  = cfg ? d70_r1_ready  : d4_r1_ready;
  assign o_rsp_valid = cfg ? d70_rsp_valid : d4_rsp_valid;
  assign o_rsp_id    = cfg ? d70_rsp_id    : d4_rsp_id;
  assign o_rsp_ans   = cfg ? d70_rsp_ans   : d4_rsp_ans;
  assign o_rsp_cout  = cfg ? d70_rsp_cout  : d4_rsp_cout;
  assign o_rsp_v     = cfg ? d70_rsp_v     : d4_rsp_v;
  assign o_busy      = cfg ? d70_busy      : d4_busy;

  addsub_share_ctrl #(.SETTLE_CYCLES(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(d4_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
    .r1_valid(r1_valid), .r1_ready(d4_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
    .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id), .rsp_ans(d4_rsp_ans),
    .rsp_cout(d4_rsp_cout), .rsp_v(d4_rsp_v), .busy(d4_busy)
  );

  addsub_share_ctrl #(.SETTLE_CYCLES(70), .CNT_W(7)) u_dut70 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(d70_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
    .r1_valid(r1_valid), .r1_ready(d70_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
    .rsp_valid(d70_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d70_rsp_id), .rsp_ans(d70_rsp_ans),
    .rsp_cout(d70_rsp_cout), .rsp_v(d70_rsp_v), .busy(d70_busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic        pop_ids[$];
  int          m_st;
  int          m_cnt;
  logic        m_last;
  int          n_acc = 0;
  int          n_rsp = 0;
  logic        chk_en = 1'b0;
  logic        last_id, last_cout, last_v;
  logic [31:0] last_ans;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cfg=%0d t=%0t)", tag, obs, exp, cfg, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    exp_t        e;
    logic [32:0] t;
    e.id = id;
    if (sub) begin
      e.ans  = a - b;
      e.cout = (a >= b);
      e.v    = (a[31] != b[31]) && (e.ans[31] != a[31]);
    end else begin
      t      = {1'b0, a} + {1'b0, b};
      e.ans  = t[31:0];
      e.cout = t[32];
      e.v    = (a[31] == b[31]) && (e.ans[31] != a[31]);
    end
    return e;
  endfunction

  // Reference model: checks outputs away from the edge, then advances the
  // expected phase to what the coming posedge should produce.
  always @(negedge clk) begin : mon
    logic er0, er1;
    int   s;
    exp_t e;
    s   = cfg ? 70 : 4;
    er0 = 1'b0;
    er1 = 1'b0;
    if (m_st == 0) begin
      if (r0_valid && r1_valid) begin
        if (m_last) er0 = 1'b1; else er1 = 1'b1;
      end else if (r0_valid) er0 = 1'b1;
      else if (r1_valid)     er1 = 1'b1;
    end
    if (chk_en) begin
      check("r0_ready", 64'(o_r0_ready), 64'(er0));
      check("r1_ready", 64'(o_r1_ready), 64'(er1));
      check("busy", 64'(o_busy), 64'(m_st != 0));
      check("rsp_valid", 64'(o_rsp_valid), 64'(m_st == 2));
      if (m_st == 2 && sb.size() > 0) begin
        check("rsp_id", 64'(o_rsp_id), 64'(sb[0].id));
        check("rsp_ans", 64'(o_rsp_ans), 64'(sb[0].ans));
        check("rsp_cout", 64'(o_rsp_cout), 64'(sb[0].cout));
        check("rsp_v", 64'(o_rsp_v), 64'(sb[0].v));
      end
    end
    if (rst) begin
      m_st   = 0;
      m_cnt  = 0;
      m_last = 1'b1;
      sb.delete();
    end else begin
      case (m_st)
        0: if (er0 || er1) begin
          sb.push_back(model(er1, er1 ? r1_a : r0_a, er1 ? r1_b : r0_b, er1 ? r1_sub : r0_sub));
          m_last = er1;
          m_cnt  = s - 1;
          m_st   = 1;
          n_acc++;
        end
        1: if (m_cnt == 0) m_st = 2; else m_cnt--;
        2: if (rsp_ready) begin
          if (sb.size() > 0) e = sb.pop_front();
          $display("rsp cfg=%0d id=%0d ans=%08h cout=%0d v=%0d", cfg, o_rsp_id, o_rsp_ans,
                   o_rsp_cout, o_rsp_v);
          last_id   = o_rsp_id;
          last_ans  = o_rsp_ans;
          last_cout = o_rsp_cout;
          last_v    = o_rsp_v;
          pop_ids.push_back(o_rsp_id);
          n_rsp++;
          m_st = 0;
        end
        default: m_st = 0;
      endcase
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(o_rsp_id), 64'(0));
    check("rst_rsp_ans", 64'(o_rsp_ans), 64'(0));
    check("rst_rsp_cout", 64'(o_rsp_cout), 64'(0));
    check("rst_rsp_v", 64'(o_rsp_v), 64'(0));
  endtask

  task automatic wait_acc(input int target);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #2;
      if (n_acc >= target) got = 1'b1;
    end
    check("accept_seen", 64'(got), 64'(1));
  endtask

  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic sub);
    int base;
    base = n_acc;
    if (id) begin
      r1_a = a; r1_b = b; r1_sub = sub; r1_valid = 1'b1;
    end else begin
      r0_a = a; r0_b = b; r0_sub = sub; r0_valid = 1'b1;
    end
    wait_acc(base + 1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #2;
      if (m_st == 0 && sb.size() == 0) done = 1'b1;
    end
    check("idle_reached", 64'(done), 64'(1));
  endtask

  task automatic expect_last(input string tag, input logic id, input logic [31:0] ans,
                             input logic cout, input logic v);
    check({tag, "_id"}, 64'(last_id), 64'(id));
    check({tag, "_ans"}, 64'(last_ans), 64'(ans));
    check({tag, "_cout"}, 64'(last_cout), 64'(cout));
    check({tag, "_v"}, 64'(last_v), 64'(v));
  endtask

  task automatic run_all();
    int  base;
    int  base_rsp;
    logic seen;
    // Basic add on requester 0.
    do_reset();
    send(1'b0, 32'h0000_0021, 32'h0000_0022, 1'b0);
    wait_idle();
    expect_last("t1", 1'b0, 32'h0000_0043, 1'b0, 1'b0);

    // Both requesters valid from reset release: alternating grants.
    r0_a = 32'h1; r0_b = 32'h2; r0_sub = 1'b0; r0_valid = 1'b1;
    r1_a = 32'hA; r1_b = 32'h3; r1_sub = 1'b1; r1_valid = 1'b1;
    do_reset();
    pop_ids.delete();
    base = n_acc;
    wait_acc(base + 4);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    wait_idle();
    check("t2_count", 64'(pop_ids.size()), 64'(4));
    if (pop_ids.size() == 4) begin
      check("t2_g0", 64'(pop_ids[0]), 64'(0));
      check("t2_g1", 64'(pop_ids[1]), 64'(1));
      check("t2_g2", 64'(pop_ids[2]), 64'(0));
      check("t2_g3", 64'(pop_ids[3]), 64'(1));
    end

    // Overflow and exact-cancel subtraction.
    send(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle();
    expect_last("t3a", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    send(1'b0, 32'h336F_B7E5, 32'h336F_B7E5, 1'b1);
    wait_idle();
    expect_last("t3b", 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Response back-pressure with both requesters waiting.
    rsp_ready = 1'b0;
    r0_a = 32'h5; r0_b = 32'h7; r0_sub = 1'b1; r0_valid = 1'b1;
    r1_a = 32'hFFFF_FFFF; r1_b = 32'h1; r1_sub = 1'b0; r1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (m_st == 2) seen = 1'b1;
    end
    check("t4_resp_seen", 64'(seen), 64'(1));
    repeat (5) @(posedge clk);
    #2;
    base = n_acc;
    rsp_ready = 1'b1;
    wait_acc(base + 1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    wait_idle();
    expect_last("t4", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Reset while settling drops the operation.
    send(1'b0, 32'h0000_0100, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    base_rsp = n_rsp;
    check("t5_busy", 64'(o_busy), 64'(0));
    check("t5_rsp_valid", 64'(o_rsp_valid), 64'(0));
    repeat (10) @(posedge clk);
    #2;
    check("t5_no_rsp", 64'(n_rsp), 64'(base_rsp));
    send(1'b1, 32'h0000_0040, 32'h0000_0002, 1'b1);
    wait_idle();
    expect_last("t5", 1'b1, 32'h0000_003E, 1'b1, 1'b0);

    // Operand churn after accept must not reach the result.
    send(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      r0_a   = $urandom;
      r0_b   = $urandom;
      r0_sub = ~r0_sub;
      #1;
      if (m_st == 0 && sb.size() == 0) seen = 1'b1;
    end
    check("t6_done", 64'(seen), 64'(1));
    expect_last("t6", 1'b0, 32'h0246_8ACF, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; r0_sub = 1'b0; r1_sub = 1'b0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    rsp_ready = 1'b1;
    cfg = 1'b0;
    run_all();
    chk_en = 1'b0;
    cfg = 1'b1;
    run_all();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
